// File: rtl/key_if_pkg.sv
// key_if_pkg: shared constants and helpers for the key debounce front end
package key_if_pkg;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam logic LVL_PRESSED = 1'b1;
  localparam logic LVL_RELEASED = 1'b0;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/key_debounce_chan.sv
// key_debounce_chan: one key channel - synchroniser, debounce counter, level, strobes and toggle
module key_debounce_chan
  import key_if_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic i_key,
  input  logic i_clear,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_toggle
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic r_sync1, r_sync2, r_level, r_press, r_release, r_toggle;
  logic [CW-1:0] r_cnt;
  logic w_same, w_accept, w_rise, w_fall;
  assign w_same = r_sync2 == r_level;
  // acceptance happens on the edge where the count would reach DEBOUNCE_CYCLES
  assign w_accept = !w_same && r_cnt == LAST;
  assign w_rise = w_accept && r_sync2 == LVL_PRESSED;
  assign w_fall = w_accept && r_sync2 == LVL_RELEASED;
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      r_sync1 <= LVL_RELEASED;
      r_sync2 <= LVL_RELEASED;
      r_cnt <= '0;
      r_level <= LVL_RELEASED;
      r_press <= 1'b0;
      r_release <= 1'b0;
      r_toggle <= 1'b0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      r_cnt <= (w_same || w_accept) ? '0 : r_cnt + 1'b1;
      r_level <= w_accept ? r_sync2 : r_level;
      r_press <= w_rise;
      r_release <= w_fall;
      r_toggle <= i_clear ? 1'b0 : r_toggle ^ w_rise;
    end
  assign o_level = r_level;
  assign o_press = r_press;
  assign o_release = r_release;
  assign o_toggle = r_toggle;
endmodule

// File: rtl/key_debounce_toggle.sv
// key_debounce_toggle: NUM_KEYS independent debounced keys with press/release strobes and toggles
module key_debounce_toggle
  import key_if_pkg::*;
#(
  parameter int NUM_KEYS = 5,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit KEY_ACTIVE_LOW = 1'b0
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [NUM_KEYS-1:0] Key_Input,
  input  logic                Clear,
  output logic [NUM_KEYS-1:0] Key_Level,
  output logic [NUM_KEYS-1:0] Key_Press,
  output logic [NUM_KEYS-1:0] Key_Release,
  output logic [NUM_KEYS-1:0] Key_Toggle
);
  logic [NUM_KEYS-1:0] w_key;
  assign w_key = Key_Input ^ {NUM_KEYS{KEY_ACTIVE_LOW}};
  genvar i;
  generate
    for (i = 0; i < NUM_KEYS; i++) begin : g_chan
      key_debounce_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .i_key    (w_key[i]),
        .i_clear  (Clear),
        .o_level  (Key_Level[i]),
        .o_press  (Key_Press[i]),
        .o_release(Key_Release[i]),
        .o_toggle (Key_Toggle[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_key_debounce_toggle.sv
// tb_key_debounce_toggle: table vectors, corner sequences and random stimulus vs a window model
module tb_key_debounce_toggle;
  localparam int N = 5;
  localparam int D = 4;
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic [N-1:0] Key_Input = '0, al_in = '1;
  logic Clear = 1'b0, al_clear = 1'b0;
  logic [N-1:0] Key_Level, Key_Press, Key_Release, Key_Toggle;
  logic [N-1:0] al_level, al_press, al_release, al_toggle;
  int n_cmp = 0, n_bad = 0;

  always #5 CLK = ~CLK;

  key_debounce_toggle #(.NUM_KEYS(N), .DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1'b0)) dut (
    .CLK(CLK), .RSTn(RSTn), .Key_Input(Key_Input), .Clear(Clear),
    .Key_Level(Key_Level), .Key_Press(Key_Press), .Key_Release(Key_Release), .Key_Toggle(Key_Toggle)
  );
  key_debounce_toggle #(.NUM_KEYS(N), .DEBOUNCE_CYCLES(D), .KEY_ACTIVE_LOW(1'b1)) dut_al (
    .CLK(CLK), .RSTn(RSTn), .Key_Input(al_in), .Clear(al_clear),
    .Key_Level(al_level), .Key_Press(al_press), .Key_Release(al_release), .Key_Toggle(al_toggle)
  );

  // Model: a level flips once the last D synchronised samples (raw delayed by two edges) all disagree with it
  logic [63:0] hist [2][N];
  logic [N-1:0] m_lvl [2], m_pr [2], m_rl [2], m_tg [2];

  task automatic model_edge();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        logic raw, clr, acc;
        raw = (k == 0) ? Key_Input[i] : ~al_in[i];
        clr = (k == 0) ? Clear : al_clear;
        if (!RSTn) begin
          hist[k][i] = '0;
          m_lvl[k][i] = 1'b0; m_pr[k][i] = 1'b0; m_rl[k][i] = 1'b0; m_tg[k][i] = 1'b0;
        end else begin
          acc = 1'b1;
          for (int j = 1; j <= D; j++) if (hist[k][i][j] == m_lvl[k][i]) acc = 1'b0;
          m_pr[k][i] = acc && !m_lvl[k][i];
          m_rl[k][i] = acc && m_lvl[k][i];
          if (acc) m_lvl[k][i] = ~m_lvl[k][i];
          m_tg[k][i] = clr ? 1'b0 : m_tg[k][i] ^ m_pr[k][i];
          hist[k][i] = {hist[k][i][62:0], raw};
        end
      end
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    chk("level", Key_Level, m_lvl[0]);
    chk("press", Key_Press, m_pr[0]);
    chk("release", Key_Release, m_rl[0]);
    chk("toggle", Key_Toggle, m_tg[0]);
    chk("al_level", al_level, m_lvl[1]);
    chk("al_press", al_press, m_pr[1]);
    chk("al_release", al_release, m_rl[1]);
    chk("al_toggle", al_toggle, m_tg[1]);
  endtask

  task automatic do_reset(input logic [N-1:0] k0);
    Key_Input = k0; al_in = '1; Clear = 1'b0; al_clear = 1'b0;
    #2 RSTn = 1'b0;
    #1;
    chk("rst_level", Key_Level, '0);
    chk("rst_press", Key_Press, '0);
    chk("rst_release", Key_Release, '0);
    chk("rst_toggle", Key_Toggle, '0);
    tick();
    tick();
    RSTn = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] key, lvl, pr, rl, tg;
  } vec_t;
  vec_t tbl [4];

  initial begin
    logic [N-1:0] pr_seen, rl_seen;
    int pcnt, rcnt;
    tbl[0] = '{key: 5'b10101, lvl: 5'b10101, pr: 5'b10101, rl: 5'b00000, tg: 5'b10101};
    tbl[1] = '{key: 5'b00001, lvl: 5'b00001, pr: 5'b00000, rl: 5'b10100, tg: 5'b10101};
    tbl[2] = '{key: 5'b00101, lvl: 5'b00101, pr: 5'b00100, rl: 5'b00000, tg: 5'b10001};
    tbl[3] = '{key: 5'b00000, lvl: 5'b00000, pr: 5'b00000, rl: 5'b00101, tg: 5'b10001};
    @(negedge CLK);
    // reset with all keys held: acceptance on the sixth edge
    do_reset(5'b11111);
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 5) chk("held_lvl_e5", Key_Level, 5'b00000);
      if (e == 6) begin
        chk("held_press_e6", Key_Press, 5'b11111);
        chk("held_lvl_e6", Key_Level, 5'b11111);
        chk("held_tg_e6", Key_Toggle, 5'b11111);
      end
      if (e == 7) chk("held_press_e7", Key_Press, 5'b00000);
    end
    // clear collides with an accepted press on key 1
    do_reset(5'b00000);
    Key_Input = 5'b00010;
    for (int e = 1; e <= 6; e++) begin
      if (e == 6) Clear = 1'b1;
      tick();
    end
    chk("clr_press", Key_Press, 5'b00010);
    chk("clr_toggle", Key_Toggle, 5'b00000);
    Clear = 1'b0;
    Key_Input = '0;
    repeat (8) tick();
    // table vectors from a fresh reset
    do_reset(5'b00000);
    for (int v = 0; v < 4; v++) begin
      Key_Input = tbl[v].key;
      pr_seen = '0; rl_seen = '0;
      repeat (8) begin
        tick();
        pr_seen |= Key_Press; rl_seen |= Key_Release;
      end
      chk($sformatf("tbl%0d_level", v), Key_Level, tbl[v].lvl);
      chk($sformatf("tbl%0d_press", v), pr_seen, tbl[v].pr);
      chk($sformatf("tbl%0d_release", v), rl_seen, tbl[v].rl);
      chk($sformatf("tbl%0d_toggle", v), Key_Toggle, tbl[v].tg);
    end
    // bounce on key 0: 3 high, 1 low, then steady high
    do_reset(5'b00000);
    Key_Input = 5'b00001; repeat (3) tick();
    Key_Input = 5'b00000; tick();
    Key_Input = 5'b00001;
    pcnt = 0; rcnt = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 5) chk("bounce_press_e5", Key_Press, 5'b00000);
      if (e == 6) chk("bounce_press_e6", Key_Press, 5'b00001);
      pcnt += int'(Key_Press[0]); rcnt += int'(Key_Release[0]);
    end
    chk("bounce_pcnt", N'(pcnt), N'(1));
    chk("bounce_rcnt", N'(rcnt), N'(0));
    chk("bounce_toggle", Key_Toggle, 5'b00001);
    // hold key 3 for 20 cycles then release
    Key_Input = 5'b01001;
    pcnt = 0; rcnt = 0;
    repeat (20) begin
      tick();
      pcnt += int'(Key_Press[3]);
    end
    chk("hold_pcnt", N'(pcnt), N'(1));
    Key_Input = 5'b00001;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 5) chk("rel_e5", Key_Release, 5'b00000);
      if (e == 6) chk("rel_e6", Key_Release, 5'b01000);
      rcnt += int'(Key_Release[3]);
    end
    chk("rel_rcnt", N'(rcnt), N'(1));
    chk("rel_toggle", Key_Toggle, 5'b01001);
    // active-low instance: idle high, bit 4 driven low
    chk("al_idle_level", al_level, 5'b00000);
    al_in = 5'b01111;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) chk("al_lvl_e5", al_level, 5'b00000);
      if (e == 6) begin
        chk("al_lvl_e6", al_level, 5'b10000);
        chk("al_press_e6", al_press, 5'b10000);
      end
    end
    // random patterns with random hold lengths and occasional clears
    for (int r = 0; r < 300; r++) begin
      Key_Input = N'($urandom);
      al_in = N'($urandom);
      repeat ($urandom_range(1, 9)) begin
        Clear = ($urandom_range(0, 7) == 0);
        al_clear = ($urandom_range(0, 7) == 0);
        tick();
      end
    end
    Clear = 1'b0; al_clear = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
